vga_axil_slave_ctrl: RTL and testbench
======================================

Name: vga_axil_slave_ctrl

Overview:
- AXI4-Lite slave front end for the VGA register/memory space.
- Converts AXI-Lite write and read transactions into single-cycle native-side strobes: write_en_o and read_en_sync_o, each with a word address.
- Read data returns from the native side one cycle after read_en_sync_o.
- Sits between the system AXI-Lite bus and the VGA native register file/memory.

Parameters:
- AXIL_ADDR_WIDTH, 32, AXI byte-address width.
- AXIL_DATA_WIDTH, 32, data width; one word = AXIL_DATA_WIDTH/8 bytes.
- NATIVE_ADDR_WIDTH, 10, native word-address width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- awaddr  in  AXIL_ADDR_WIDTH; awvalid in 1; awready out 1.
- wdata  in  AXIL_DATA_WIDTH; wstrb in AXIL_DATA_WIDTH/8; wvalid in 1; wready out 1.
- bresp  out  2; bvalid out 1; bready in 1.
- araddr  in  AXIL_ADDR_WIDTH; arvalid in 1; arready out 1.
- rdata  out  AXIL_DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1.
- data_i  in  AXIL_DATA_WIDTH  native read data, valid the cycle after read_en_sync_o.
- addr_write_o  out  NATIVE_ADDR_WIDTH  native write word address.
- addr_read_o  out  NATIVE_ADDR_WIDTH  native read word address.
- data_o  out  AXIL_DATA_WIDTH  native write data.
- read_en_sync_o  out  1  one-cycle native read strobe.
- write_en_o  out  1  one-cycle native write strobe.

Behaviour:
- Reset (arst_n low, asynchronous): all ready/valid outputs, strobes, addresses, data and resp registers = 0. FSMs return to IDLE. Any in-flight transaction is dropped.
- Address mapping: native address = axil_addr[NATIVE_ADDR_WIDTH+1:2]. Low 2 bits and upper bits are ignored; no alignment error.
- Write FSM states: W_IDLE, W_STROBE, W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured.
  - AW and W may arrive in either order or the same cycle. Each is latched on its handshake, and its ready drops after capture.
  - When both are held, go to W_STROBE.
  - W_STROBE (1 cycle): write_en_o=1, addr_write_o and data_o hold the latched values. The native side samples them on that clock edge.
  - Next state W_RESP: bvalid=1, bresp=OKAY (2'b00). Hold until bready, then return to W_IDLE.
  - wstrb is ignored; the full word is always written.
- Read FSM states: R_IDLE, R_FETCH, R_WAIT, R_RESP.
  - R_IDLE: arready=1; on arvalid handshake, latch the address and go to R_FETCH.
  - R_FETCH (1 cycle): read_en_sync_o=1 and addr_read_o valid.
  - R_WAIT (1 cycle): data_i now valid; capture into rdata.
  - R_RESP: rvalid=1, rresp=OKAY. Hold rdata until rready, then return to R_IDLE.
  - Read latency from AR handshake to rvalid = 3 cycles.
- Read and write FSMs are independent. Both strobes may assert in the same cycle, including to the same address; no ordering between them is guaranteed.
- When rvalid/bvalid are held with ready low, all payload stays stable (AXI rule). No new transaction is accepted on that channel meanwhile.
- addr_*_o and data_o hold their last value between strobes.
- Responses are always OKAY; SLVERR/DECERR are never generated.
- Reset asserted mid-transaction aborts it with no response. After release, the FSMs start in IDLE.

Test Plan:
- Reset: hold arst_n=0 for 100 ns -> all valids, readys and strobes 0; after release, awready=wready=arready=1.
- Sequential writes: 10 writes to addr 0x0,0x4,...,0x24 with data equal to addr -> each produces one write_en_o pulse with addr_write_o=0..9 and data_o=addr, plus bresp=OKAY.
- Sequential reads of the same 10 addresses, with a native model returning data_i the cycle after read_en_sync_o -> rdata equals written data, rresp=OKAY, read_en_sync_o pulses exactly once per read.
- W before AW by 3 cycles, then AW before W -> exactly one write_en_o per pair, with correct address/data.
- Backpressure: bready=0 for 5 cycles and rready=0 for 5 cycles -> bvalid/rvalid and rdata stay stable, no extra strobes.
- Reset asserted during W_RESP and during R_FETCH -> outputs clear immediately; a following write/read to 0x8 completes normally.

Source files
------------

// File: rtl/vga_axil_slave_ctrl_if.sv
// AXI4-Lite bus bundle shared by the VGA slave front end and whatever masters it.
// The master modport drives requests; the slave modport answers them.
interface vga_axil_slave_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/vga_axil_slave_ctrl.sv
// AXI4-Lite slave that turns bus writes/reads into one-cycle native strobes for the
// VGA register file; independent write and read FSMs, responses always OKAY.
module vga_axil_slave_ctrl #(
  parameter int AXIL_ADDR_WIDTH   = 32,
  parameter int AXIL_DATA_WIDTH   = 32,
  parameter int NATIVE_ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         arst_n,
  vga_axil_slave_ctrl_if.slave         axil,
  input  logic [AXIL_DATA_WIDTH-1:0]   data_i,
  output logic [NATIVE_ADDR_WIDTH-1:0] addr_write_o,
  output logic [NATIVE_ADDR_WIDTH-1:0] addr_read_o,
  output logic [AXIL_DATA_WIDTH-1:0]   data_o,
  output logic                         read_en_sync_o,
  output logic                         write_en_o
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_STROBE, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_WAIT, R_RESP} rstate_e;

  wstate_e                      wstate_q;
  rstate_e                      rstate_q;

  logic                         awready_q;
  logic                         wready_q;
  logic                         bvalid_q;
  logic                         aw_held_q;
  logic                         w_held_q;
  logic [NATIVE_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXIL_DATA_WIDTH-1:0]   w_data_q;
  logic [NATIVE_ADDR_WIDTH-1:0] addr_write_q;
  logic [AXIL_DATA_WIDTH-1:0]   data_q;
  logic                         write_en_q;

  logic                         arready_q;
  logic                         rvalid_q;
  logic [AXIL_DATA_WIDTH-1:0]   rdata_q;
  logic [NATIVE_ADDR_WIDTH-1:0] addr_read_q;
  logic                         read_en_q;

  logic                         aw_hs;
  logic                         w_hs;
  logic                         ar_hs;
  logic                         aw_have;
  logic                         w_have;
  logic [NATIVE_ADDR_WIDTH-1:0] waddr_d;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_d;

  assign aw_hs   = axil.awvalid & awready_q;
  assign w_hs    = axil.wvalid & wready_q;
  assign ar_hs   = axil.arvalid & arready_q;
  assign aw_have = aw_held_q | aw_hs;
  assign w_have  = w_held_q | w_hs;

  // A channel captured on the same edge that completes the pair bypasses its holding register.
  assign waddr_d = aw_held_q ? aw_addr_q : axil.awaddr[NATIVE_ADDR_WIDTH+1:2];
  assign wdata_d = w_held_q ? w_data_q : axil.wdata;

  // Byte lanes and out-of-window address bits carry no meaning for this word-only space.
  logic unused_bits;
  assign unused_bits = ^{axil.wstrb,
                         axil.awaddr[AXIL_ADDR_WIDTH-1:NATIVE_ADDR_WIDTH+2], axil.awaddr[1:0],
                         axil.araddr[AXIL_ADDR_WIDTH-1:NATIVE_ADDR_WIDTH+2], axil.araddr[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register in the block
  // sees pre-edge values; later assignments in the same branch take priority.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wstate_q     <= W_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      addr_write_q <= '0;
      data_q       <= '0;
      write_en_q   <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= axil.awaddr[NATIVE_ADDR_WIDTH+1:2];
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            w_data_q <= axil.wdata;
            w_held_q <= 1'b1;
          end
          if (aw_have && w_have) begin
            addr_write_q <= waddr_d;
            data_q       <= wdata_d;
            write_en_q   <= 1'b1;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            wstate_q     <= W_STROBE;
          end else begin
            awready_q <= ~aw_have;
            wready_q  <= ~w_have;
          end
        end
        W_STROBE: begin
          write_en_q <= 1'b0;
          bvalid_q   <= 1'b1;
          wstate_q   <= W_RESP;
        end
        W_RESP: begin
          if (axil.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rstate_q    <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      addr_read_q <= '0;
      read_en_q   <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            addr_read_q <= axil.araddr[NATIVE_ADDR_WIDTH+1:2];
            read_en_q   <= 1'b1;
            arready_q   <= 1'b0;
            rstate_q    <= R_FETCH;
          end
        end
        R_FETCH: begin
          read_en_q <= 1'b0;
          rstate_q  <= R_WAIT;
        end
        R_WAIT: begin
          // Native data is valid exactly one cycle after the strobe.
          rdata_q  <= data_i;
          rvalid_q <= 1'b1;
          rstate_q <= R_RESP;
        end
        R_RESP: begin
          if (axil.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign axil.awready   = awready_q;
  assign axil.wready    = wready_q;
  assign axil.bvalid    = bvalid_q;
  assign axil.bresp     = RESP_OKAY;
  assign axil.arready   = arready_q;
  assign axil.rvalid    = rvalid_q;
  assign axil.rdata     = rdata_q;
  assign axil.rresp     = RESP_OKAY;

  assign addr_write_o   = addr_write_q;
  assign data_o         = data_q;
  assign write_en_o     = write_en_q;
  assign addr_read_o    = addr_read_q;
  assign read_en_sync_o = read_en_q;

endmodule

// File: tb/tb_vga_axil_slave_ctrl.sv
// Directed bench for vga_axil_slave_ctrl: AXI-Lite master tasks, a native memory model
// and strobe monitors; expected values are hand-computed from the stimulus.
module tb_vga_axil_slave_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] data_i = '0;
  logic [9:0]  addr_write_o;
  logic [9:0]  addr_read_o;
  logic [31:0] data_o;
  logic        read_en_sync_o;
  logic        write_en_o;

  int n_checks = 0;
  int n_errors = 0;

  int          wcount = 0;
  int          rcount = 0;
  logic [9:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [9:0]  last_raddr = '0;

  logic [31:0] mem [0:1023] = '{default: 32'hFFFF_FFFF};

  vga_axil_slave_ctrl_if #(.ADDR_W(32), .DATA_W(32)) axil ();

  vga_axil_slave_ctrl #(
    .AXIL_ADDR_WIDTH  (32),
    .AXIL_DATA_WIDTH  (32),
    .NATIVE_ADDR_WIDTH(10)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .axil          (axil),
    .data_i        (data_i),
    .addr_write_o  (addr_write_o),
    .addr_read_o   (addr_read_o),
    .data_o        (data_o),
    .read_en_sync_o(read_en_sync_o),
    .write_en_o    (write_en_o)
  );

  always #5 clk = ~clk;

  // Native side: samples write strobe on the edge, returns read data one cycle later.
  always @(posedge clk) begin
    if (write_en_o) mem[addr_write_o] <= data_o;
    if (read_en_sync_o) data_i <= mem[addr_read_o];
  end

  always @(negedge clk) begin
    if (arst_n && write_en_o) begin
      wcount++;
      last_waddr = addr_write_o;
      last_wdata = data_o;
    end
    if (arst_n && read_en_sync_o) begin
      rcount++;
      last_raddr = addr_read_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_hold,
                            output logic [1:0] resp);
    bit aw_pend = 0, w_pend = 0, aw_done = 0, w_done = 0, got_b = 0;
    int bv_cnt = 0;
    resp = 2'b11;
    axil.bready = 1'b0;
    for (int k = 0; k < 60 && !got_b; k++) begin
      @(negedge clk);
      if (aw_pend) begin axil.awvalid = 1'b0; aw_done = 1; aw_pend = 0; end
      if (w_pend)  begin axil.wvalid  = 1'b0; w_done  = 1; w_pend  = 0; end
      if (w_done && !aw_done && bv_cnt == 0) check("wready_drop", axil.wready, 1'b0);
      if (aw_done && !w_done && bv_cnt == 0) check("awready_drop", axil.awready, 1'b0);
      if (k == aw_dly) begin axil.awaddr = addr; axil.awvalid = 1'b1; end
      if (k == w_dly)  begin axil.wdata = data; axil.wstrb = 4'hF; axil.wvalid = 1'b1; end
      aw_pend = axil.awvalid && axil.awready;
      w_pend  = axil.wvalid && axil.wready;
      if (axil.bvalid) begin
        if (bv_cnt > 0) check("bresp_stable", {30'd0, axil.bresp}, 32'd0);
        if (bv_cnt >= b_hold) begin
          axil.bready = 1'b1;
          got_b = 1;
          resp = axil.bresp;
        end
        bv_cnt++;
      end
    end
    check("b_timeout", {31'd0, got_b}, 32'd1);
    @(negedge clk);
    axil.bready = 1'b0;
    check("bvalid_drop", {31'd0, axil.bvalid}, 32'd0);
  endtask

  task automatic axil_read(input logic [31:0] addr, input int r_hold,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit ar_pend = 0, got_r = 0;
    int hs_k = -1;
    int rv_cnt = 0;
    logic [31:0] first = '0;
    data = '0;
    resp = 2'b11;
    lat  = -1;
    axil.rready = 1'b0;
    for (int k = 0; k < 60 && !got_r; k++) begin
      @(negedge clk);
      if (ar_pend) begin axil.arvalid = 1'b0; ar_pend = 0; end
      if (k == 0) begin axil.araddr = addr; axil.arvalid = 1'b1; end
      if (axil.arvalid && axil.arready) begin ar_pend = 1; hs_k = k; end
      if (axil.rvalid) begin
        if (rv_cnt == 0) begin
          first = axil.rdata;
          lat   = k - hs_k;
        end else begin
          check("rdata_stable", axil.rdata, first);
        end
        if (rv_cnt >= r_hold) begin
          axil.rready = 1'b1;
          got_r = 1;
          data  = axil.rdata;
          resp  = axil.rresp;
        end
        rv_cnt++;
      end
    end
    check("r_timeout", {31'd0, got_r}, 32'd1);
    @(negedge clk);
    axil.rready = 1'b0;
    check("rvalid_drop", {31'd0, axil.rvalid}, 32'd0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;
    int          w0, r0;
    bit          seen;

    axil.awaddr = '0; axil.awvalid = 1'b0;
    axil.wdata  = '0; axil.wstrb   = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;

    // Reset held for 100 ns.
    #50;
    check("rst_awready", {31'd0, axil.awready}, 32'd0);
    check("rst_wready",  {31'd0, axil.wready},  32'd0);
    check("rst_arready", {31'd0, axil.arready}, 32'd0);
    check("rst_bvalid",  {31'd0, axil.bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, axil.rvalid},  32'd0);
    check("rst_strobes", {30'd0, write_en_o, read_en_sync_o}, 32'd0);
    check("rst_addr",    {12'd0, addr_write_o, addr_read_o}, 32'd0);
    check("rst_data",    data_o, 32'd0);
    check("rst_rdata",   axil.rdata, 32'd0);
    #50;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_readys", {29'd0, axil.awready, axil.wready, axil.arready}, 32'd7);

    // Sequential writes, data = byte address.
    for (int i = 0; i < 10; i++) begin
      w0 = wcount;
      axil_write(32'(i * 4), 32'(i * 4), 0, 0, 0, resp);
      check("seq_w_count", 32'(wcount - w0), 32'd1);
      check("seq_w_addr",  {22'd0, last_waddr}, 32'(i));
      check("seq_w_data",  last_wdata, 32'(i * 4));
      check("seq_w_bresp", {30'd0, resp}, 32'd0);
    end

    // Sequential reads of the same words.
    for (int i = 0; i < 10; i++) begin
      r0 = rcount;
      axil_read(32'(i * 4), 0, rd, resp, lat);
      check("seq_r_data",  rd, 32'(i * 4));
      check("seq_r_rresp", {30'd0, resp}, 32'd0);
      check("seq_r_count", 32'(rcount - r0), 32'd1);
      check("seq_r_addr",  {22'd0, last_raddr}, 32'(i));
      check("seq_r_lat",   32'(lat), 32'd3);
    end

    // W leads AW by 3 cycles, then AW leads W; low address bits and upper bits are ignored.
    w0 = wcount;
    axil_write(32'hF000_0032, 32'h1234_5678, 3, 0, 0, resp);
    check("wfirst_count", 32'(wcount - w0), 32'd1);
    check("wfirst_addr",  {22'd0, last_waddr}, 32'd12);
    check("wfirst_data",  last_wdata, 32'h1234_5678);
    w0 = wcount;
    axil_write(32'h0000_0034, 32'hCAFE_F00D, 0, 3, 0, resp);
    check("awfirst_count", 32'(wcount - w0), 32'd1);
    check("awfirst_addr",  {22'd0, last_waddr}, 32'd13);
    check("awfirst_data",  last_wdata, 32'hCAFE_F00D);
    axil_read(32'h30, 0, rd, resp, lat);
    check("wfirst_readback", rd, 32'h1234_5678);
    axil_read(32'h34, 0, rd, resp, lat);
    check("awfirst_readback", rd, 32'hCAFE_F00D);

    // Backpressure on both response channels.
    w0 = wcount;
    r0 = rcount;
    axil_write(32'h38, 32'h0BAD_BEEF, 0, 0, 5, resp);
    check("bp_w_count", 32'(wcount - w0), 32'd1);
    check("bp_w_bresp", {30'd0, resp}, 32'd0);
    axil_read(32'h38, 5, rd, resp, lat);
    check("bp_r_data",  rd, 32'h0BAD_BEEF);
    check("bp_r_count", 32'(rcount - r0), 32'd1);
    check("bp_no_extra_w", 32'(wcount - w0), 32'd1);

    // Reset during W_RESP.
    @(negedge clk);
    axil.awaddr = 32'h40; axil.awvalid = 1'b1;
    axil.wdata = 32'h5555_AAAA; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (axil.bvalid) seen = 1;
    end
    check("wresp_reached", {31'd0, seen}, 32'd1);
    #1 arst_n = 1'b0;
    #1;
    check("wrst_bvalid",  {31'd0, axil.bvalid}, 32'd0);
    check("wrst_awready", {30'd0, axil.awready, axil.wready}, 32'd0);
    check("wrst_outputs", {12'd0, addr_write_o, addr_read_o}, 32'd0);
    check("wrst_data",    data_o, 32'd0);
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    w0 = wcount;
    axil_write(32'h8, 32'h8888_0008, 0, 0, 0, resp);
    check("wrst_after_count", 32'(wcount - w0), 32'd1);
    check("wrst_after_addr",  {22'd0, last_waddr}, 32'd2);
    check("wrst_after_data",  last_wdata, 32'h8888_0008);

    // Reset during R_FETCH.
    @(negedge clk);
    axil.araddr = 32'h8;
    axil.arvalid = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (read_en_sync_o) seen = 1;
    end
    check("rfetch_reached", {31'd0, seen}, 32'd1);
    axil.arvalid = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    check("rrst_strobe",  {31'd0, read_en_sync_o}, 32'd0);
    check("rrst_rvalid",  {31'd0, axil.rvalid}, 32'd0);
    check("rrst_arready", {31'd0, axil.arready}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    r0 = rcount;
    axil_read(32'h8, 0, rd, resp, lat);
    check("rrst_after_data",  rd, 32'h8888_0008);
    check("rrst_after_count", 32'(rcount - r0), 32'd1);
    check("rrst_after_lat",   32'(lat), 32'd3);

    // Idle tail: no stray strobes.
    w0 = wcount;
    r0 = rcount;
    repeat (5) @(negedge clk);
    check("idle_no_strobes", 32'((wcount - w0) + (rcount - r0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
